// File: rtl/tpu_tile_scheduler_pkg.sv
// Shared constants and state encoding for the tile scheduler that drives the
// fixed-size tpu core over arbitrary matrix shapes.
package tpu_tile_scheduler_pkg;

    localparam int unsigned ARRAY_DIM  = 32'd10;
    localparam int unsigned ADDR_WIDTH = 32'd16;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(ARRAY_DIM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Job bus between the tile scheduler (master) and the tpu core (slave).
interface tpu_tile_scheduler_if;
    import tpu_tile_scheduler_pkg::*;

    logic                  tpu_start;
    logic                  tpu_valid;
    logic [ADDR_WIDTH-1:0] tpu_m;
    logic [ADDR_WIDTH-1:0] tpu_k;
    logic [ADDR_WIDTH-1:0] tpu_n;
    logic [ADDR_WIDTH-1:0] tpu_base_a;
    logic [ADDR_WIDTH-1:0] tpu_base_b;
    logic [ADDR_WIDTH-1:0] tpu_base_p;

    modport master (
        output tpu_start, tpu_m, tpu_k, tpu_n, tpu_base_a, tpu_base_b, tpu_base_p,
        input  tpu_valid
    );

    modport slave (
        input  tpu_start, tpu_m, tpu_k, tpu_n, tpu_base_a, tpu_base_b, tpu_base_p,
        output tpu_valid
    );

endinterface

// File: rtl/tpu_tile_scheduler_tile_dim_calc.sv
// Clamps a remaining row/column count to one array edge and flags the final
// tile along that axis.
module tile_dim_calc
    import tpu_tile_scheduler_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] rem_i,
    output logic [ADDR_WIDTH-1:0] dim_o,
    output logic                  last_o
);

    // min(ARRAY_DIM, remaining) and whether this tile exhausts the axis
    always_comb begin
        if (rem_i > TILE_STEP) begin
            dim_o  = TILE_STEP;
            last_o = 1'b0;
        end else begin
            dim_o  = rem_i;
            last_o = 1'b1;
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Splits an MxKxN multiply into row-major output tiles and issues one tpu job
// per tile, waiting for each job to complete before issuing the next.
module tpu_tile_scheduler
    import tpu_tile_scheduler_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [ADDR_WIDTH-1:0] base_p_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    tpu_tile_scheduler_if.master  tpu_if
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] k_q, n_q, base_a_q, base_b_q, base_p_q;
    logic [ADDR_WIDTH-1:0] rem_m_q, rem_n_q, a_off_q, b_off_q, p_off_q;
    logic                  row_last_q, col_last_q, abort_q;
    logic                  busy_q, done_q, aborted_q, start_q;
    logic [ADDR_WIDTH-1:0] tile_m_q, tile_k_q, tile_n_q;
    logic [ADDR_WIDTH-1:0] tile_a_q, tile_b_q, tile_p_q;

    logic                  idle_s, zero_dim_s, load_s, last_tile_s, abort_pend_s, in_job_s;
    logic [ADDR_WIDTH-1:0] rem_m_d, rem_n_d, a_off_d, b_off_d, p_off_d, k_d;
    logic [ADDR_WIDTH-1:0] tile_m_d, tile_n_d, tile_a_d, tile_b_d, tile_p_d;
    logic                  row_last_d, col_last_d;

    // Next-tile counters/offsets: seeded from the inputs in IDLE, advanced
    // row-major (column inner) otherwise. Sums wrap at ADDR_WIDTH bits.
    always_comb begin
        idle_s = (state_q == S_IDLE);
        if (idle_s) begin
            k_d      = k_i;
            rem_m_d  = m_i;
            rem_n_d  = n_i;
            a_off_d  = ADDR_ZERO;
            b_off_d  = ADDR_ZERO;
            p_off_d  = ADDR_ZERO;
            tile_a_d = base_a_i;
            tile_b_d = base_b_i;
            tile_p_d = base_p_i;
        end else begin
            k_d     = k_q;
            p_off_d = p_off_q + TILE_STEP;
            if (col_last_q) begin
                rem_m_d = rem_m_q - TILE_STEP;
                rem_n_d = n_q;
                a_off_d = a_off_q + k_q;
                b_off_d = ADDR_ZERO;
            end else begin
                rem_m_d = rem_m_q;
                rem_n_d = rem_n_q - TILE_STEP;
                a_off_d = a_off_q;
                b_off_d = b_off_q + k_q;
            end
            tile_a_d = base_a_q + a_off_d;
            tile_b_d = base_b_q + b_off_d;
            tile_p_d = base_p_q + p_off_d;
        end
    end

    // Control qualifiers for the state machine
    always_comb begin
        zero_dim_s   = (m_i == ADDR_ZERO) || (k_i == ADDR_ZERO) || (n_i == ADDR_ZERO);
        last_tile_s  = row_last_q && col_last_q;
        abort_pend_s = abort_q || abort_i;
        in_job_s     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
        load_s       = (idle_s && start_i && !zero_dim_s) || (state_q == S_NEXT);
    end

    tile_dim_calc u_row_calc (
        .rem_i  (rem_m_d),
        .dim_o  (tile_m_d),
        .last_o (row_last_d)
    );

    tile_dim_calc u_col_calc (
        .rem_i  (rem_n_d),
        .dim_o  (tile_n_d),
        .last_o (col_last_d)
    );

    // Sequencer: state, job latches, tile registers and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            k_q        <= ADDR_ZERO;
            n_q        <= ADDR_ZERO;
            base_a_q   <= ADDR_ZERO;
            base_b_q   <= ADDR_ZERO;
            base_p_q   <= ADDR_ZERO;
            rem_m_q    <= ADDR_ZERO;
            rem_n_q    <= ADDR_ZERO;
            a_off_q    <= ADDR_ZERO;
            b_off_q    <= ADDR_ZERO;
            p_off_q    <= ADDR_ZERO;
            row_last_q <= 1'b0;
            col_last_q <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            start_q    <= 1'b0;
            tile_m_q   <= ADDR_ZERO;
            tile_k_q   <= ADDR_ZERO;
            tile_n_q   <= ADDR_ZERO;
            tile_a_q   <= ADDR_ZERO;
            tile_b_q   <= ADDR_ZERO;
            tile_p_q   <= ADDR_ZERO;
        end else begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_q      <= k_i;
                        n_q      <= n_i;
                        base_a_q <= base_a_i;
                        base_b_q <= base_b_i;
                        base_p_q <= base_p_i;
                        abort_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (zero_dim_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tpu_if.tpu_valid) begin
                        if (abort_pend_s) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            aborted_q <= 1'b1;
                        end else if (last_tile_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    state_q <= S_ISSUE;
                    start_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // An abort is remembered until the in-flight tile reports back
            if (in_job_s && abort_i) begin
                abort_q <= 1'b1;
            end

            if (load_s) begin
                rem_m_q    <= rem_m_d;
                rem_n_q    <= rem_n_d;
                a_off_q    <= a_off_d;
                b_off_q    <= b_off_d;
                p_off_q    <= p_off_d;
                row_last_q <= row_last_d;
                col_last_q <= col_last_d;
                tile_m_q   <= tile_m_d;
                tile_k_q   <= k_d;
                tile_n_q   <= tile_n_d;
                tile_a_q   <= tile_a_d;
                tile_b_q   <= tile_b_d;
                tile_p_q   <= tile_p_d;
            end
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign aborted_o         = aborted_q;
    assign tpu_if.tpu_start  = start_q;
    assign tpu_if.tpu_m      = tile_m_q;
    assign tpu_if.tpu_k      = tile_k_q;
    assign tpu_if.tpu_n      = tile_n_q;
    assign tpu_if.tpu_base_a = tile_a_q;
    assign tpu_if.tpu_base_b = tile_b_q;
    assign tpu_if.tpu_base_p = tile_p_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler; the bench plays the tpu core and
// checks every issued job against hand-computed tile tables.
module tb_tpu_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i;
    logic [15:0] m_i, k_i, n_i, base_a_i, base_b_i, base_p_i;
    logic        busy_o, done_o, aborted_o;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    logic [15:0] ex_m[0:8], ex_k[0:8], ex_n[0:8], ex_a[0:8], ex_b[0:8], ex_p[0:8];

    tpu_tile_scheduler_if tpu_if();

    tpu_tile_scheduler dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .m_i       (m_i),
        .k_i       (k_i),
        .n_i       (n_i),
        .base_a_i  (base_a_i),
        .base_b_i  (base_b_i),
        .base_p_i  (base_p_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .aborted_o (aborted_o),
        .tpu_if    (tpu_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tpu_if.tpu_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_job(input int j, input logic [15:0] m, k, n, a, b, p);
        ex_m[j] = m; ex_k[j] = k; ex_n[j] = n;
        ex_a[j] = a; ex_b[j] = b; ex_p[j] = p;
    endtask

    task automatic launch(input logic [15:0] m, k, n, a, b, p);
        m_i = m; k_i = k; n_i = n;
        base_a_i = a; base_b_i = b; base_p_i = p;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic expect_job(input int j);
        chk($sformatf("start[%0d]", j),  {31'd0, tpu_if.tpu_start}, 32'd1);
        chk($sformatf("busy[%0d]", j),   {31'd0, busy_o}, 32'd1);
        chk($sformatf("m[%0d]", j),      {16'd0, tpu_if.tpu_m}, {16'd0, ex_m[j]});
        chk($sformatf("k[%0d]", j),      {16'd0, tpu_if.tpu_k}, {16'd0, ex_k[j]});
        chk($sformatf("n[%0d]", j),      {16'd0, tpu_if.tpu_n}, {16'd0, ex_n[j]});
        chk($sformatf("base_a[%0d]", j), {16'd0, tpu_if.tpu_base_a}, {16'd0, ex_a[j]});
        chk($sformatf("base_b[%0d]", j), {16'd0, tpu_if.tpu_base_b}, {16'd0, ex_b[j]});
        chk($sformatf("base_p[%0d]", j), {16'd0, tpu_if.tpu_base_p}, {16'd0, ex_p[j]});
    endtask

    // Runs nj tiles from the ISSUE cycle onward. abort_at raises abort_i in that
    // tile's WAIT; noisy injects a start/input change and spurious valids.
    task automatic run_seq(input int nj, input int abort_at, input bit noisy);
        for (int j = 0; j < nj; j++) begin
            expect_job(j);
            tpu_if.tpu_valid = 1'b0;
            tick();
            chk("start_one_cycle", {31'd0, tpu_if.tpu_start}, 32'd0);
            if (noisy && j == 0) begin
                start_i = 1'b1;
                m_i     = 16'd99;
            end
            if (j == abort_at) abort_i = 1'b1;
            tick();
            start_i = 1'b0;
            abort_i = 1'b0;
            chk("wait_holds", {31'd0, done_o}, 32'd0);
            tpu_if.tpu_valid = 1'b1;
            tick();
            tpu_if.tpu_valid = 1'b0;
            if (j == nj - 1 || j == abort_at) begin
                chk("done_pulse", {31'd0, done_o}, 32'd1);
                chk("aborted", {31'd0, aborted_o}, (j == abort_at) ? 32'd1 : 32'd0);
                tick();
                chk("done_clear", {31'd0, done_o}, 32'd0);
                chk("idle_busy", {31'd0, busy_o}, 32'd0);
                return;
            end
            chk("next_no_done", {31'd0, done_o}, 32'd0);
            chk("next_no_start", {31'd0, tpu_if.tpu_start}, 32'd0);
            if (noisy) tpu_if.tpu_valid = 1'b1;
            tick();
        end
    endtask

    initial begin
        int s0;
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        m_i = 16'd0; k_i = 16'd0; n_i = 16'd0;
        base_a_i = 16'd0; base_b_i = 16'd0; base_p_i = 16'd0;
        tpu_if.tpu_valid = 1'b0;
        tick(); tick();
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_abort", {31'd0, aborted_o}, 32'd0);
        chk("rst_start", {31'd0, tpu_if.tpu_start}, 32'd0);
        chk("rst_m",     {16'd0, tpu_if.tpu_m}, 32'd0);
        chk("rst_base_p", {16'd0, tpu_if.tpu_base_p}, 32'd0);
        rst_ni = 1'b1;
        tick();

        // single full tile
        set_job(0, 16'd10, 16'd10, 16'd10, 16'd0, 16'd100, 16'd200);
        s0 = start_cnt;
        launch(16'd10, 16'd10, 16'd10, 16'd0, 16'd100, 16'd200);
        run_seq(1, -1, 1'b0);
        chk("jobs_single", start_cnt - s0, 32'd1);

        // 25x7x13 -> 3x2 tiles with ragged edges
        set_job(0, 16'd10, 16'd7, 16'd10, 16'd0,  16'd0, 16'd500);
        set_job(1, 16'd10, 16'd7, 16'd3,  16'd0,  16'd7, 16'd510);
        set_job(2, 16'd10, 16'd7, 16'd10, 16'd7,  16'd0, 16'd520);
        set_job(3, 16'd10, 16'd7, 16'd3,  16'd7,  16'd7, 16'd530);
        set_job(4, 16'd5,  16'd7, 16'd10, 16'd14, 16'd0, 16'd540);
        set_job(5, 16'd5,  16'd7, 16'd3,  16'd14, 16'd7, 16'd550);
        s0 = start_cnt;
        launch(16'd25, 16'd7, 16'd13, 16'd0, 16'd0, 16'd500);
        run_seq(6, -1, 1'b0);
        chk("jobs_ragged", start_cnt - s0, 32'd6);

        // zero K finishes immediately without a tpu job
        s0 = start_cnt;
        launch(16'd5, 16'd0, 16'd5, 16'd1, 16'd2, 16'd3);
        chk("zero_done",  {31'd0, done_o}, 32'd1);
        chk("zero_busy",  {31'd0, busy_o}, 32'd1);
        chk("zero_abort", {31'd0, aborted_o}, 32'd0);
        tick();
        chk("zero_done_clear", {31'd0, done_o}, 32'd0);
        chk("zero_idle", {31'd0, busy_o}, 32'd0);
        chk("zero_no_job", start_cnt - s0, 32'd0);

        // 20x4x20 with a restart attempt, input change and spurious valids
        set_job(0, 16'd10, 16'd4, 16'd10, 16'd1000, 16'd2000, 16'd3000);
        set_job(1, 16'd10, 16'd4, 16'd10, 16'd1000, 16'd2004, 16'd3010);
        set_job(2, 16'd10, 16'd4, 16'd10, 16'd1004, 16'd2000, 16'd3020);
        set_job(3, 16'd10, 16'd4, 16'd10, 16'd1004, 16'd2004, 16'd3030);
        s0 = start_cnt;
        launch(16'd20, 16'd4, 16'd20, 16'd1000, 16'd2000, 16'd3000);
        run_seq(4, -1, 1'b1);
        tick(); tick();
        chk("jobs_noisy", start_cnt - s0, 32'd4);

        // 30x2x30 aborted during the second tile
        set_job(0, 16'd10, 16'd2, 16'd10, 16'd0, 16'd0, 16'd0);
        set_job(1, 16'd10, 16'd2, 16'd10, 16'd0, 16'd2, 16'd10);
        s0 = start_cnt;
        launch(16'd30, 16'd2, 16'd30, 16'd0, 16'd0, 16'd0);
        run_seq(9, 1, 1'b0);
        tick(); tick(); tick();
        chk("jobs_abort", start_cnt - s0, 32'd2);

        // asynchronous reset in WAIT, then a fresh job from tile 0
        launch(16'd30, 16'd2, 16'd30, 16'd9, 16'd9, 16'd9);
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy_o}, 32'd0);
        chk("arst_done",  {31'd0, done_o}, 32'd0);
        chk("arst_start", {31'd0, tpu_if.tpu_start}, 32'd0);
        chk("arst_n",     {16'd0, tpu_if.tpu_n}, 32'd0);
        chk("arst_base_a", {16'd0, tpu_if.tpu_base_a}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        set_job(0, 16'd10, 16'd3, 16'd10, 16'd5, 16'd6, 16'd7);
        set_job(1, 16'd2,  16'd3, 16'd10, 16'd8, 16'd6, 16'd17);
        s0 = start_cnt;
        launch(16'd12, 16'd3, 16'd10, 16'd5, 16'd6, 16'd7);
        run_seq(2, -1, 1'b0);
        chk("jobs_after_reset", start_cnt - s0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
